dlsc_mt9v032_timing_mc: RTL and testbench
=========================================

DLSC_MT9V032_TIMING_MC -- requirements
Module: dlsc_mt9v032_timing_mc

Interface
REQ-001 SHALL have parameter CHANNELS, default 2, lockstep sensor lanes (1..4).
REQ-002 SHALL have parameter DATA, default 10, bits per pixel word (8..12).
REQ-003 SHALL have parameters HBITS and VBITS, default 10 each, line/frame counter widths.
REQ-004 SHALL have parameter FIFO_DEPTH, default 16, output buffer words (power of 2, 4..64).
REQ-005 SHALL have ports clk (input, 1, sole clock) and rst_n (input, 1); one clock; reset is asynchronous and active-low.
REQ-006 SHALL have clk_en (input, 1), sample qualifier; enable (input, 1), pixel forwarding enable.
REQ-007 SHALL have hdisp (input, HBITS) and vdisp (input, VBITS), expected resolution.
REQ-008 SHALL have in_data (input, CHANNELS*DATA), lane 0 in LSBs.
REQ-009 SHALL have out_ready (input, 1); out_valid, out_first, out_last (output, 1 each); out_data (output, CHANNELS*DATA).
REQ-010 SHALL have obs_hdisp (output, HBITS) and obs_vdisp (output, VBITS), measured resolution.
REQ-011 SHALL have single-cycle pulse outputs res_okay, res_error, sync_error, frame_start, frame_end, overrun, plus level output frame_valid.

Function
REQ-012 SHALL sample in_data only when clk_en=1; all FSM/counter updates SHALL occur only on sampled words.
REQ-013 Sync word SHALL be the all-ones prefix on every lane, followed by a code word: 1=frame start (FS, opens line), 2=line start (LS), 3=line end (LE), 4=frame end (FE).
REQ-014 FSM states SHALL be IDLE, FRAME, LINE, PREFIX; PREFIX returns to the state implied by the code (FS/LS->LINE, LE->FRAME, FE->IDLE).
REQ-015 Legal transitions: FS only from IDLE; LS only from FRAME; LE only from LINE; FE only from FRAME. Any other code, a code >4, lanes disagreeing, or a partial prefix SHALL pulse sync_error and go to IDLE.
REQ-016 A pixel word in FRAME SHALL pulse sync_error and go to IDLE; pixel words in IDLE SHALL be ignored.
REQ-017 enable SHALL be latched at FS; pixels of that frame are forwarded only if the latched value is 1.
REQ-018 Each pixel SHALL be held in a staging register and pushed when the next pixel is sampled (last=0) or when LE is decoded (last=1); first=1 on the first pixel after FS.
REQ-019 hcnt SHALL count pixels per line, saturating at 2^HBITS-1; on LE obs_hdisp<=hcnt. vcnt SHALL count LE events; on FE obs_vdisp<=vcnt.
REQ-020 On FE: frame_end pulse; res_okay if obs values equal hdisp/vdisp, else res_error (same cycle as frame_end, using the updated obs values).
REQ-021 frame_start SHALL pulse on FS; frame_valid SHALL be 1 from FS decode until FE decode or any sync_error.
REQ-022 FIFO SHALL be first-word-fall-through; a pushed word is visible on out_* the next cycle; a transfer occurs when out_valid && out_ready.
REQ-023 A push with FIFO full and no same-cycle pop SHALL be dropped, pulse overrun, and suppress pushes until the next FS; full with simultaneous pop SHALL accept the push.
REQ-024 sync_error mid-line SHALL discard the staging register without pushing.

Reset
REQ-025 rst_n low SHALL asynchronously set FSM=IDLE, clear FIFO, staging register, counters, obs_hdisp/obs_vdisp, and all outputs to 0.
REQ-026 Reset mid-frame SHALL lose the frame; the first accepted frame after reset begins at the next FS.

Configuration
REQ-027 Macro DLSC_MT9V032_TIMING_MC_RES_CHECK_EN defined: REQ-019/020 measurement and comparison active.
REQ-028 Macro undefined: obs_hdisp/obs_vdisp tied 0, res_okay/res_error tied 0, counters removed; all other behaviour unchanged.

Structure
REQ-029 Package dlsc_mt9v032_pkg SHALL hold the sync code constants (FS/LS/LE/FE) and the FSM state encoding.
REQ-030 FIFO SHALL be sub-module dlsc_mt9v032_pxfifo (width CHANNELS*DATA+2, depth FIFO_DEPTH).

Verification (CHANNELS=2, DATA=10, hdisp=4, vdisp=2, clk_en=1)
REQ-031 Nominal frame FS,4px,LE,LS,4px,LE,FE, out_ready=1 -> 8 words, first on word 0, last on words 3/7, res_okay=1, obs=4x2.
REQ-032 Second line of 5 pixels -> obs_hdisp=5 after LE, res_error pulse at FE, no res_okay.
REQ-033 Lane 1 sends code 2 while lane 0 sends code 3 -> sync_error, frame_valid=0, staged pixel not output.
REQ-034 out_ready=0, frame of 20 pixels, FIFO_DEPTH=16 -> exactly 16 words held, one overrun pulse, remainder of frame dropped; next frame accepted after drain.
REQ-035 enable=0 at FS then 1 mid-frame -> no words output for that frame; frame_start/frame_end still pulse.
REQ-036 rst_n low mid-line with 3 words buffered -> out_valid=0 immediately; next FS frame output correctly.

Source files
------------

// File: rtl/dlsc_mt9v032_timing_mc_pkg.sv
// Shared constants for the MT9V032 timing decoder: sync code values and FSM state encoding.
package dlsc_mt9v032_pkg;

  localparam int unsigned CODE_FS = 1;
  localparam int unsigned CODE_LS = 2;
  localparam int unsigned CODE_LE = 3;
  localparam int unsigned CODE_FE = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FRAME,
    ST_LINE,
    ST_PREFIX
  } state_t;

endpackage

// File: rtl/dlsc_mt9v032_timing_mc_if.sv
// Pixel output stream: valid/ready handshake with first/last markers.
interface dlsc_mt9v032_timing_mc_if #(
  parameter int unsigned WIDTH = 20
) ();

  logic             out_valid;
  logic             out_ready;
  logic             out_first;
  logic             out_last;
  logic [WIDTH-1:0] out_data;

  modport master (output out_valid, output out_first, output out_last, output out_data,
                  input out_ready);
  modport slave  (input out_valid, input out_first, input out_last, input out_data,
                  output out_ready);

endinterface

// File: rtl/dlsc_mt9v032_pxfifo.sv
// First-word-fall-through pixel buffer; push_ready also covers full-with-same-cycle-pop.
module dlsc_mt9v032_pxfifo #(
  parameter int unsigned WIDTH = 22,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             push_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  localparam int unsigned AB = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AB-1:0]    wr_ptr;
  logic [AB-1:0]    rd_ptr;
  logic [AB:0]      count;
  logic             pop;
  logic             wr;

  assign out_valid  = (count != '0);
  assign pop        = out_valid && out_ready;
  assign push_ready = (count != (AB+1)'(DEPTH)) || pop;
  assign wr         = push && push_ready;
  assign out_data   = out_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr)  wr_ptr <= wr_ptr + AB'(1);
      if (pop) rd_ptr <= rd_ptr + AB'(1);
      case ({wr, pop})
        2'b10:   count <= count + (AB+1)'(1);
        2'b01:   count <= count - (AB+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dlsc_mt9v032_timing_mc.sv
// MT9V032 multi-lane sync decoder with pixel staging and output FIFO.
// Resolution measurement/check is built only when DLSC_MT9V032_TIMING_MC_RES_CHECK_EN is defined.
module dlsc_mt9v032_timing_mc
  import dlsc_mt9v032_pkg::*;
#(
  parameter int unsigned CHANNELS   = 2,
  parameter int unsigned DATA       = 10,
  parameter int unsigned HBITS      = 10,
  parameter int unsigned VBITS      = 10,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clk_en,
  input  logic                     enable,
  input  logic [HBITS-1:0]         hdisp,
  input  logic [VBITS-1:0]         vdisp,
  input  logic [CHANNELS*DATA-1:0] in_data,
  dlsc_mt9v032_timing_mc_if.master out,
  output logic [HBITS-1:0]         obs_hdisp,
  output logic [VBITS-1:0]         obs_vdisp,
  output logic                     res_okay,
  output logic                     res_error,
  output logic                     sync_error,
  output logic                     frame_start,
  output logic                     frame_end,
  output logic                     overrun,
  output logic                     frame_valid
);

  localparam int unsigned W = CHANNELS*DATA;

  state_t          st, st_nx, ret, ret_nx;
  logic [W-1:0]    stage_data;
  logic            stage_valid, stage_first;
  logic            first_pend, en_lat, suppress;

  logic            all_ones, any_ones, lanes_agree;
  logic [DATA-1:0] code;
  logic            ev_fs, ev_ls, ev_le, ev_fe, ev_px, ev_err;
  logic            push_req, push_last, push_en, push_ready, drop;
  logic [W+1:0]    fifo_dout;

  always_comb begin
    all_ones    = 1'b1;
    any_ones    = 1'b0;
    lanes_agree = 1'b1;
    code        = in_data[DATA-1:0];
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (in_data[i*DATA +: DATA] == '1) any_ones = 1'b1;
      else                               all_ones = 1'b0;
      if (in_data[i*DATA +: DATA] != code) lanes_agree = 1'b0;
    end
  end

  // ret remembers the state the prefix interrupted, so the code can be checked against it
  always_comb begin
    st_nx  = st;
    ret_nx = ret;
    ev_fs  = 1'b0;
    ev_ls  = 1'b0;
    ev_le  = 1'b0;
    ev_fe  = 1'b0;
    ev_px  = 1'b0;
    ev_err = 1'b0;
    if (clk_en) begin
      case (st)
        ST_PREFIX: begin
          if (!lanes_agree)                                    ev_err = 1'b1;
          else if (code == DATA'(CODE_FS) && ret == ST_IDLE)   ev_fs  = 1'b1;
          else if (code == DATA'(CODE_LS) && ret == ST_FRAME)  ev_ls  = 1'b1;
          else if (code == DATA'(CODE_LE) && ret == ST_LINE)   ev_le  = 1'b1;
          else if (code == DATA'(CODE_FE) && ret == ST_FRAME)  ev_fe  = 1'b1;
          else                                                 ev_err = 1'b1;
        end
        default: begin
          if (all_ones) begin
            st_nx  = ST_PREFIX;
            ret_nx = st;
          end else if (any_ones) begin
            ev_err = 1'b1;
          end else if (st == ST_LINE) begin
            ev_px = 1'b1;
          end else if (st == ST_FRAME) begin
            ev_err = 1'b1;
          end
        end
      endcase
      if (ev_fs || ev_ls) st_nx = ST_LINE;
      if (ev_le)          st_nx = ST_FRAME;
      if (ev_fe || ev_err) st_nx = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st  <= ST_IDLE;
      ret <= ST_IDLE;
    end else begin
      st  <= st_nx;
      ret <= ret_nx;
    end
  end

  assign push_req  = stage_valid && (ev_px || ev_le);
  assign push_last = ev_le;
  assign push_en   = push_req && en_lat && !suppress;
  assign drop      = push_en && !push_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_data  <= '0;
      stage_valid <= 1'b0;
      stage_first <= 1'b0;
      first_pend  <= 1'b0;
      en_lat      <= 1'b0;
      suppress    <= 1'b0;
      frame_valid <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      sync_error  <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      frame_start <= ev_fs;
      frame_end   <= ev_fe;
      sync_error  <= ev_err;
      overrun     <= drop;
      if (ev_fs) begin
        en_lat      <= enable;
        suppress    <= 1'b0;
        first_pend  <= 1'b1;
        stage_valid <= 1'b0;
        frame_valid <= 1'b1;
      end
      if (ev_fe || ev_err) frame_valid <= 1'b0;
      if (ev_px) begin
        stage_data  <= in_data;
        stage_valid <= 1'b1;
        stage_first <= first_pend;
        first_pend  <= 1'b0;
      end
      if (ev_le || ev_fe || ev_err) stage_valid <= 1'b0;
      if (drop) suppress <= 1'b1;
    end
  end

  dlsc_mt9v032_pxfifo #(
    .WIDTH (W + 2),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push_en),
    .push_data  ({stage_first, push_last, stage_data}),
    .push_ready (push_ready),
    .out_valid  (out.out_valid),
    .out_ready  (out.out_ready),
    .out_data   (fifo_dout)
  );

  assign out.out_first = fifo_dout[W+1];
  assign out.out_last  = fifo_dout[W];
  assign out.out_data  = fifo_dout[W-1:0];

`ifdef DLSC_MT9V032_TIMING_MC_RES_CHECK_EN
  logic [HBITS-1:0] hcnt;
  logic [VBITS-1:0] vcnt;

  // obs_hdisp was captured at the last LE; vcnt is the value obs_vdisp takes this cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt      <= '0;
      vcnt      <= '0;
      obs_hdisp <= '0;
      obs_vdisp <= '0;
      res_okay  <= 1'b0;
      res_error <= 1'b0;
    end else begin
      res_okay  <= ev_fe && (obs_hdisp == hdisp) && (vcnt == vdisp);
      res_error <= ev_fe && !((obs_hdisp == hdisp) && (vcnt == vdisp));
      if (ev_fs || ev_ls)              hcnt <= '0;
      else if (ev_px && hcnt != '1)    hcnt <= hcnt + HBITS'(1);
      if (ev_fs)                       vcnt <= '0;
      else if (ev_le && vcnt != '1)    vcnt <= vcnt + VBITS'(1);
      if (ev_le) obs_hdisp <= hcnt;
      if (ev_fe) obs_vdisp <= vcnt;
    end
  end
`else
  logic unused_res;
  assign unused_res = ^{hdisp, vdisp};
  assign obs_hdisp  = '0;
  assign obs_vdisp  = '0;
  assign res_okay   = 1'b0;
  assign res_error  = 1'b0;
`endif

endmodule

// File: tb/tb_dlsc_mt9v032_timing_mc.sv
// Directed self-checking bench for dlsc_mt9v032_timing_mc (CHANNELS=2, DATA=10, depth 16).
module tb_dlsc_mt9v032_timing_mc;

  localparam int unsigned DW = 10;
  localparam int unsigned W  = 20;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clk_en = 1'b0;
  logic          enable = 1'b1;
  logic [9:0]    hdisp = 10'd4;
  logic [9:0]    vdisp = 10'd2;
  logic [W-1:0]  in_data = '0;
  logic [9:0]    obs_hdisp, obs_vdisp;
  logic          res_okay, res_error, sync_error, frame_start, frame_end, overrun, frame_valid;

  dlsc_mt9v032_timing_mc_if #(.WIDTH(W)) out_if ();

  dlsc_mt9v032_timing_mc #(
    .CHANNELS   (2),
    .DATA       (10),
    .HBITS      (10),
    .VBITS      (10),
    .FIFO_DEPTH (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clk_en      (clk_en),
    .enable      (enable),
    .hdisp       (hdisp),
    .vdisp       (vdisp),
    .in_data     (in_data),
    .out         (out_if),
    .obs_hdisp   (obs_hdisp),
    .obs_vdisp   (obs_vdisp),
    .res_okay    (res_okay),
    .res_error   (res_error),
    .sync_error  (sync_error),
    .frame_start (frame_start),
    .frame_end   (frame_end),
    .overrun     (overrun),
    .frame_valid (frame_valid)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [W+1:0] got[$];
  int n_fs = 0, n_fe = 0, n_err = 0, n_ok = 0, n_rerr = 0, n_ovr = 0;

  always @(negedge clk) begin
    if (out_if.out_valid && out_if.out_ready)
      got.push_back({out_if.out_first, out_if.out_last, out_if.out_data});
    if (frame_start) n_fs++;
    if (frame_end)   n_fe++;
    if (sync_error)  n_err++;
    if (res_okay)    n_ok++;
    if (res_error)   n_rerr++;
    if (overrun)     n_ovr++;
  end

  function automatic logic [W-1:0] pix(input int ln, input int p);
    logic [DW-1:0] a, b;
    a = DW'(ln*32 + p + 1);
    b = DW'(ln*32 + p + 201);
    return {b, a};
  endfunction

  task automatic send(input logic [W-1:0] w);
    @(posedge clk); #2;
    in_data = w;
    clk_en  = 1'b1;
  endtask

  task automatic idle(input int n);
    @(posedge clk); #2;
    clk_en  = 1'b0;
    in_data = '0;
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic sync(input int c);
    logic [DW-1:0] cc;
    cc = DW'(c);
    send('1);
    send({cc, cc});
  endtask

  task automatic frame(input int n0, input int n1);
    sync(1);
    for (int p = 0; p < n0; p++) send(pix(0, p));
    sync(3);
    sync(2);
    for (int p = 0; p < n1; p++) send(pix(1, p));
    sync(3);
    sync(4);
  endtask

  task automatic test_reset();
    logic [W+12+19:0] v;
    @(negedge clk);
    v = {out_if.out_valid, out_if.out_first, out_if.out_last, out_if.out_data, frame_valid,
         sync_error, frame_start, frame_end, overrun, res_okay, res_error, obs_hdisp, obs_vdisp};
    tests++;
    if (v !== '0) begin fails++; $display("FAIL reset_outputs got %h want 0", v); end
    idle(1);
    rst_n = 1'b1;
    idle(2);
    tests++;
    if (out_if.out_valid !== 1'b0 || frame_valid !== 1'b0) begin
      fails++; $display("FAIL post_reset_idle got valid=%b fv=%b want 0/0", out_if.out_valid, frame_valid);
    end
  endtask

  task automatic test_nominal();
    int q0 = got.size();
    int fs0 = n_fs, fe0 = n_fe, er0 = n_err, ok0 = n_ok;
    logic [W+1:0] exp;
    int exp_ok;
    logic [9:0] exp_h, exp_v;
`ifdef DLSC_MT9V032_TIMING_MC_RES_CHECK_EN
    exp_ok = 1; exp_h = 10'd4; exp_v = 10'd2;
`else
    exp_ok = 0; exp_h = 10'd0; exp_v = 10'd0;
`endif
    frame(4, 4);
    idle(10);
    tests++;
    if (got.size() - q0 !== 8) begin fails++; $display("FAIL nominal_count got %0d want 8", got.size() - q0); end
    for (int i = 0; i < 8; i++) begin
      exp = {i == 0, (i % 4) == 3, pix(i / 4, i % 4)};
      tests++;
      if (q0 + i >= got.size() || got[q0+i] !== exp) begin
        fails++; $display("FAIL nominal_word%0d got %h want %h", i, (q0 + i < got.size()) ? got[q0+i] : '0, exp);
      end
    end
    tests++;
    if (n_fs - fs0 !== 1 || n_fe - fe0 !== 1 || n_err - er0 !== 0) begin
      fails++; $display("FAIL nominal_pulses got fs=%0d fe=%0d err=%0d want 1/1/0", n_fs - fs0, n_fe - fe0, n_err - er0);
    end
    tests++;
    if (n_ok - ok0 !== exp_ok) begin fails++; $display("FAIL nominal_res_okay got %0d want %0d", n_ok - ok0, exp_ok); end
    tests++;
    if (obs_hdisp !== exp_h || obs_vdisp !== exp_v) begin
      fails++; $display("FAIL nominal_obs got %0dx%0d want %0dx%0d", obs_hdisp, obs_vdisp, exp_h, exp_v);
    end
    tests++;
    if (frame_valid !== 1'b0) begin fails++; $display("FAIL nominal_frame_valid got %b want 0", frame_valid); end
  endtask

  task automatic test_res_error();
    int q0 = got.size();
    int ok0 = n_ok, re0 = n_rerr;
    logic [W+1:0] exp;
    int exp_re;
    logic [9:0] exp_h;
`ifdef DLSC_MT9V032_TIMING_MC_RES_CHECK_EN
    exp_re = 1; exp_h = 10'd5;
`else
    exp_re = 0; exp_h = 10'd0;
`endif
    frame(4, 5);
    idle(10);
    tests++;
    if (got.size() - q0 !== 9) begin fails++; $display("FAIL reserr_count got %0d want 9", got.size() - q0); end
    exp = {1'b0, 1'b1, pix(1, 4)};
    tests++;
    if (q0 + 8 >= got.size() || got[q0+8] !== exp) begin
      fails++; $display("FAIL reserr_last_word got %h want %h", (q0 + 8 < got.size()) ? got[q0+8] : '0, exp);
    end
    tests++;
    if (obs_hdisp !== exp_h) begin fails++; $display("FAIL reserr_obs_hdisp got %0d want %0d", obs_hdisp, exp_h); end
    tests++;
    if (n_rerr - re0 !== exp_re || n_ok - ok0 !== 0) begin
      fails++; $display("FAIL reserr_pulses got err=%0d ok=%0d want %0d/0", n_rerr - re0, n_ok - ok0, exp_re);
    end
  endtask

  task automatic test_sync_error();
    int q0 = got.size();
    int er0 = n_err, fe0 = n_fe;
    logic [W+1:0] exp;
    sync(1);
    send(pix(0, 0));
    tests++;
    if (frame_valid !== 1'b1) begin fails++; $display("FAIL syncerr_fv_open got %b want 1", frame_valid); end
    send(pix(0, 1));
    send('1);
    send({DW'(2), DW'(3)});
    idle(8);
    tests++;
    if (n_err - er0 !== 1) begin fails++; $display("FAIL syncerr_pulse got %0d want 1", n_err - er0); end
    tests++;
    if (frame_valid !== 1'b0 || n_fe - fe0 !== 0) begin
      fails++; $display("FAIL syncerr_fv got fv=%b fe=%0d want 0/0", frame_valid, n_fe - fe0);
    end
    tests++;
    if (got.size() - q0 !== 1) begin fails++; $display("FAIL syncerr_count got %0d want 1", got.size() - q0); end
    exp = {1'b1, 1'b0, pix(0, 0)};
    tests++;
    if (q0 >= got.size() || got[q0] !== exp) begin
      fails++; $display("FAIL syncerr_word got %h want %h", (q0 < got.size()) ? got[q0] : '0, exp);
    end
  endtask

  task automatic test_overrun();
    int q0 = got.size();
    int ov0 = n_ovr;
    logic [W+1:0] exp;
    out_if.out_ready = 1'b0;
    sync(1);
    for (int p = 0; p < 20; p++) send(pix(0, p));
    sync(3);
    sync(4);
    idle(4);
    tests++;
    if (out_if.out_valid !== 1'b1 || got.size() - q0 !== 0) begin
      fails++; $display("FAIL overrun_held got valid=%b xfers=%0d want 1/0", out_if.out_valid, got.size() - q0);
    end
    tests++;
    if (n_ovr - ov0 !== 1) begin fails++; $display("FAIL overrun_pulse got %0d want 1", n_ovr - ov0); end
    out_if.out_ready = 1'b1;
    idle(24);
    tests++;
    if (got.size() - q0 !== 16) begin fails++; $display("FAIL overrun_drain_count got %0d want 16", got.size() - q0); end
    for (int i = 0; i < 16; i++) begin
      exp = {i == 0, 1'b0, pix(0, i)};
      tests++;
      if (q0 + i >= got.size() || got[q0+i] !== exp) begin
        fails++; $display("FAIL overrun_word%0d got %h want %h", i, (q0 + i < got.size()) ? got[q0+i] : '0, exp);
      end
    end
    tests++;
    if (out_if.out_valid !== 1'b0) begin fails++; $display("FAIL overrun_empty got %b want 0", out_if.out_valid); end
    q0 = got.size();
    frame(4, 4);
    idle(10);
    tests++;
    if (got.size() - q0 !== 8) begin fails++; $display("FAIL overrun_next_count got %0d want 8", got.size() - q0); end
    exp = {1'b0, 1'b1, pix(1, 3)};
    tests++;
    if (q0 + 7 >= got.size() || got[q0+7] !== exp) begin
      fails++; $display("FAIL overrun_next_last got %h want %h", (q0 + 7 < got.size()) ? got[q0+7] : '0, exp);
    end
  endtask

  task automatic test_enable();
    int q0 = got.size();
    int fs0 = n_fs, fe0 = n_fe;
    enable = 1'b0;
    sync(1);
    send(pix(0, 0));
    send(pix(0, 1));
    enable = 1'b1;
    send(pix(0, 2));
    send(pix(0, 3));
    sync(3);
    sync(2);
    for (int p = 0; p < 4; p++) send(pix(1, p));
    sync(3);
    sync(4);
    idle(10);
    tests++;
    if (got.size() - q0 !== 0) begin fails++; $display("FAIL enable_words got %0d want 0", got.size() - q0); end
    tests++;
    if (n_fs - fs0 !== 1 || n_fe - fe0 !== 1) begin
      fails++; $display("FAIL enable_pulses got fs=%0d fe=%0d want 1/1", n_fs - fs0, n_fe - fe0);
    end
  endtask

  task automatic test_reset_midline();
    int q0;
    logic [W+1:0] exp;
    out_if.out_ready = 1'b0;
    sync(1);
    for (int p = 0; p < 4; p++) send(pix(0, p));
    idle(2);
    tests++;
    if (out_if.out_valid !== 1'b1) begin fails++; $display("FAIL rstmid_buffered got %b want 1", out_if.out_valid); end
    rst_n = 1'b0;
    #1;
    tests++;
    if (out_if.out_valid !== 1'b0 || frame_valid !== 1'b0) begin
      fails++; $display("FAIL rstmid_async got valid=%b fv=%b want 0/0", out_if.out_valid, frame_valid);
    end
    idle(2);
    rst_n = 1'b1;
    out_if.out_ready = 1'b1;
    q0 = got.size();
    frame(4, 4);
    idle(10);
    tests++;
    if (got.size() - q0 !== 8) begin fails++; $display("FAIL rstmid_count got %0d want 8", got.size() - q0); end
    for (int i = 0; i < 8; i++) begin
      exp = {i == 0, (i % 4) == 3, pix(i / 4, i % 4)};
      tests++;
      if (q0 + i >= got.size() || got[q0+i] !== exp) begin
        fails++; $display("FAIL rstmid_word%0d got %h want %h", i, (q0 + i < got.size()) ? got[q0+i] : '0, exp);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    out_if.out_ready = 1'b1;
    test_reset();
    test_nominal();
    test_res_error();
    test_sync_error();
    test_overrun();
    test_enable();
    test_reset_midline();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
